// File: rtl/serial_bit_source_pkg.sv
// Shared definitions for the bit-serial source and the detector-side bench.
// Holds the FSM state encoding and the default word width.
// No logic; import with serial_bit_source_pkg::*.
package serial_bit_source_pkg;

   localparam int DEFAULT_DATA_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end: takes DATA_W-bit words and emits one bit per clock.
// Latency: first bit on out_bit the cycle after the accept edge; back-to-back words without a bubble.
// Backpressure: in_ready only in IDLE or on an un-held last beat; hold freezes shifting and drops out_valid.
module serial_bit_source
   import serial_bit_source_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              hold,
   output logic              out_bit,
   output logic              out_valid,
   output logic              out_last,
   output logic              busy,
   output logic [CNT_W-1:0]  words_sent
);

   localparam int BC_W = $clog2(DATA_W);
   localparam logic [BC_W-1:0] BC_LOAD = BC_W'(DATA_W - 1);

   state_t             r_state;
   logic [DATA_W-1:0]  r_shreg;
   logic [BC_W-1:0]    r_bitcnt;
   logic [CNT_W-1:0]   r_words_sent;

   logic               w_busy;
   logic               w_last_beat;
   logic               w_accept;
   logic [DATA_W-1:0]  w_shifted;

   assign w_busy      = (r_state == ST_SHIFT);
   assign w_last_beat = w_busy & (r_bitcnt == '0);

   // Ready is combinational on hold so a new word can land on the edge that retires the last bit.
   assign in_ready = rst & (~w_busy | (w_last_beat & ~hold));
   assign w_accept = in_valid & in_ready;

   // The output end is fixed by bit order; zeros enter at the far end and never reach the output.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shifted = {r_shreg[DATA_W-2:0], 1'b0};
         assign out_bit   = r_shreg[DATA_W-1];
      end else begin : g_lsb
         assign w_shifted = {1'b0, r_shreg[DATA_W-1:1]};
         assign out_bit   = r_shreg[0];
      end
   endgenerate

   assign out_valid  = w_busy & ~hold;
   assign out_last   = w_last_beat;
   assign busy       = w_busy;
   assign words_sent = r_words_sent;

   // FSM, shift register, bit counter and completed-word counter; shreg is cleared on
   // return to IDLE so out_bit reads 0 whenever nothing is loaded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_shreg      <= '0;
         r_bitcnt     <= '0;
         r_words_sent <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_shreg  <= in_data;
                  r_bitcnt <= BC_LOAD;
                  r_state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (!hold) begin
                  if (r_bitcnt != '0) begin
                     r_shreg  <= w_shifted;
                     r_bitcnt <= r_bitcnt - BC_W'(1);
                  end else begin
                     r_words_sent <= r_words_sent + CNT_W'(1);
                     if (w_accept) begin
                        r_shreg  <= in_data;
                        r_bitcnt <= BC_LOAD;
                     end else begin
                        r_shreg <= '0;
                        r_state <= ST_IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: an 8-bit MSB-first instance and a 4-bit LSB-first instance with a 2-bit counter.
// Every cycle is compared against a bit-queue reference model; directed tables and sequences cover corners.
// A behavioural 1101 detector consumes the out_valid-gated stream.
module tb_serial_bit_source;
   import serial_bit_source_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       hold = 1'b0;

   logic        a_ir, a_ob, a_ov, a_ol, a_busy;
   logic [15:0] a_ws;
   logic        b_ir, b_ob, b_ov, b_ol, b_busy;
   logic [1:0]  b_ws;

   serial_bit_source #(.DATA_W(8), .MSB_FIRST(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_ir),
      .hold(hold), .out_bit(a_ob), .out_valid(a_ov), .out_last(a_ol), .busy(a_busy),
      .words_sent(a_ws)
   );

   serial_bit_source #(.DATA_W(4), .MSB_FIRST(1'b0), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .in_data(in_data[3:0]), .in_valid(in_valid), .in_ready(b_ir),
      .hold(hold), .out_bit(b_ob), .out_valid(b_ov), .out_last(b_ol), .busy(b_busy),
      .words_sent(b_ws)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: remaining bits of the current word in transmit order, plus a word count.
   int  sel, m_dw, m_msb, m_cw;
   bit  mq[$];
   int  mw;

   // Outputs of the selected instance as sampled in the most recent step.
   logic        o_ir, o_ob, o_ov, o_ol, o_busy;
   logic [15:0] o_ws;

   logic [3:0] det_hist;
   int         det_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic select(input int s);
      sel   = s;
      m_dw  = (s == 0) ? 8 : 4;
      m_msb = (s == 0) ? 1 : 0;
      m_cw  = (s == 0) ? 16 : 2;
   endtask

   // One clock: drive at the falling edge, sample 1ns later, advance the model at the rising edge.
   task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic h);
      logic e_ir, e_ob, e_ov, e_ol, e_busy, acc;
      int   e_ws, idx;
      rst = r; in_valid = iv; in_data = d; hold = h;
      #1;
      if (!r) begin
         mq.delete();
         mw = 0;
      end
      e_busy = (mq.size() > 0);
      e_ob   = e_busy ? mq[0] : 1'b0;
      e_ol   = e_busy && (mq.size() == 1);
      e_ov   = e_busy && !h;
      e_ir   = r && (!e_busy || (mq.size() == 1 && !h));
      e_ws   = mw % (1 << m_cw);
      if (sel == 0) begin
         o_ir = a_ir; o_ob = a_ob; o_ov = a_ov; o_ol = a_ol; o_busy = a_busy; o_ws = a_ws;
      end else begin
         o_ir = b_ir; o_ob = b_ob; o_ov = b_ov; o_ol = b_ol; o_busy = b_busy; o_ws = {14'd0, b_ws};
      end
      chk("model ws|busy,last,valid,bit,ready",
          {o_ws, 11'd0, o_busy, o_ol, o_ov, o_ob, o_ir},
          {e_ws[15:0], 11'd0, e_busy, e_ol, e_ov, e_ob, e_ir});
      @(posedge clk);
      if (o_ov === 1'b1) begin
         det_hist = {det_hist[2:0], o_ob};
         if (det_hist == 4'b1101) det_cnt++;
      end
      if (r) begin
         acc = iv && e_ir;
         if (e_busy && !h) begin
            void'(mq.pop_front());
            if (mq.size() == 0) mw++;
         end
         if (acc) begin
            for (int i = 0; i < m_dw; i++) begin
               idx = (m_msb != 0) ? (m_dw - 1 - i) : i;
               mq.push_back(d[idx]);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("reset in_ready", {31'd0, o_ir}, 32'd0);
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      det_hist = '0;
      det_cnt  = 0;
   endtask

   typedef struct {
      logic        iv;
      logic [7:0]  d;
      logic        h;
      logic        e_ir, e_ov, e_ob, e_ol;
      logic [15:0] e_ws;
   } vec_t;

   vec_t tbl[10];
   int   wrap_exp[5];

   initial begin
      logic [7:0] w;
      logic [7:0] rd;
      int cnt_a, cnt_b, bits;

      // Directed table: a single 8'hD0 word, MSB first.
      w = 8'hD0;
      tbl[0] = '{1'b1, 8'hD0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      for (int k = 1; k <= 8; k++)
         tbl[k] = '{1'b0, 8'h00, 1'b0, (k == 8), 1'b1, w[8-k], (k == 8), 16'd0};
      tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
      wrap_exp = '{1, 2, 3, 0, 1};

      @(negedge clk);
      select(0);
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step(1'b1, tbl[k].iv, tbl[k].d, tbl[k].h);
         chk($sformatf("table D0 beat %0d ws|ready,valid,bit,last", k),
             {o_ws, 12'd0, o_ir, o_ov, o_ob, o_ol},
             {tbl[k].e_ws, 12'd0, tbl[k].e_ir, tbl[k].e_ov, tbl[k].e_ob, tbl[k].e_ol});
      end
      chk("detector 1101 hits on D0", det_cnt, 1);

      // Back-to-back A5 then 3C with in_valid held high.
      do_reset();
      step(1'b1, 1'b1, 8'hA5, 1'b0);
      cnt_a = 0; cnt_b = 0;
      for (int c = 1; c <= 16; c++) begin
         step(1'b1, (c <= 8), 8'h3C, 1'b0);
         cnt_a += int'(o_ov);
         cnt_b += int'(o_ir);
      end
      chk("b2b valid cycles", cnt_a, 16);
      chk("b2b ready pulses", cnt_b, 2);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("b2b words_sent", o_ws, 2);

      // Hold for 3 cycles after bit 3 of F0.
      do_reset();
      step(1'b1, 1'b1, 8'hF0, 1'b0);
      cnt_a = 0;
      for (int c = 1; c <= 11; c++) begin
         step(1'b1, 1'b0, 8'h00, (c >= 4 && c <= 6));
         cnt_a += int'(o_ov);
         if (c >= 4 && c <= 6)
            chk("hold frozen bit,valid,last", {29'd0, o_ob, o_ov, o_ol}, {29'd0, 3'b100});
      end
      chk("hold valid count over 11 cycles", cnt_a, 8);
      chk("hold last on cycle 11", {31'd0, o_ol}, 32'd1);
      // Hold on the final bit of 55: out_last stays up while out_valid drops.
      step(1'b1, 1'b1, 8'h55, 1'b0);
      for (int c = 1; c <= 7; c++) step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int c = 0; c < 2; c++) begin
         step(1'b1, 1'b1, 8'hEE, 1'b1);
         chk("held last bit,valid,last,ready", {28'd0, o_ob, o_ov, o_ol, o_ir}, {28'd0, 4'b1010});
      end
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("released last valid,last", {30'd0, o_ov, o_ol}, 32'd3);

      // Reset in the middle of FF, then a clean 0D.
      step(1'b1, 1'b1, 8'hFF, 1'b0);
      for (int c = 1; c <= 3; c++) step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("mid-word reset valid", {31'd0, o_ov}, 32'd0);
      chk("mid-word reset words_sent", o_ws, 0);
      step(1'b1, 1'b1, 8'h0D, 1'b0);
      chk("ready after reset release", {31'd0, o_ir}, 32'd1);
      rd = '0;
      for (int c = 1; c <= 8; c++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0);
         rd = {rd[6:0], o_ob};
      end
      chk("post-reset word bits", rd, 8'h0D);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("post-reset words_sent", o_ws, 1);

      // LSB-first 4-bit word 1011.
      select(1);
      do_reset();
      step(1'b1, 1'b1, 8'h0B, 1'b0);
      bits = 0; cnt_a = 0;
      for (int c = 1; c <= 4; c++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0);
         bits = (bits << 1) | int'(o_ob);
         cnt_a += int'(o_ol);
      end
      chk("lsb-first bit order", bits, 32'b1101);
      chk("lsb-first last count", cnt_a, 1);
      chk("lsb-first last on 4th", {31'd0, o_ol}, 32'd1);

      // Two-bit counter wraps after four words.
      do_reset();
      for (int n = 0; n < 5; n++) begin
         rd = 8'(n + 3);
         step(1'b1, 1'b1, rd, 1'b0);
         for (int c = 1; c <= 4; c++) step(1'b1, 1'b0, 8'h00, 1'b0);
         step(1'b1, 1'b0, 8'h00, 1'b0);
         chk($sformatf("wrap words_sent after word %0d", n + 1), o_ws, wrap_exp[n]);
      end

      // Random traffic with hold and occasional reset on both instances.
      for (int s = 0; s < 2; s++) begin
         select(s);
         do_reset();
         for (int c = 0; c < 500; c++) begin
            rd = 8'($urandom);
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), rd,
                 ($urandom_range(0, 3) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
